// File: rtl/frame_minmax_tracker_pkg.sv
// Shared types for the frame min/max tracker slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the result record layout for the default
// configuration, and the index-width helper used by the top.
package frame_minmax_tracker_pkg;

  // Width of an index able to address n positions; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WIDTH_DEF     = 16;
  localparam int FRAME_LEN_DEF = 8;
  localparam int IDX_W_DEF     = idx_width(FRAME_LEN_DEF);
  localparam int CNT_W_DEF     = $clog2(FRAME_LEN_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One result record per frame, laid out for the default configuration.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] min_v;
    logic [WIDTH_DEF-1:0] max_v;
    logic [IDX_W_DEF-1:0] min_idx;
    logic [IDX_W_DEF-1:0] max_idx;
    logic [CNT_W_DEF-1:0] count;
  } rec_t;

endpackage

// File: rtl/frame_minmax_tracker_mag_cmp.sv
// Unsigned magnitude comparator: agb = a>b, asb = a<b, aeb = a==b.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: a, b (WIDTH, unsigned operands); agb/asb/aeb (one-hot result).
module mag_cmp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             agb,
  output logic             asb,
  output logic             aeb
);

  assign agb = (a > b);
  assign asb = (a < b);
  assign aeb = (a == b);

endmodule

// File: rtl/frame_minmax_tracker_minmax_update.sv
// Next-state min/max/index computation for one accepted sample.
// Latency: combinational.
// Backpressure: n/a; the caller decides whether the result is committed.
//
// Ports: sample, cur_min/cur_max with their indices, pos (position of the
// sample in the frame); nxt_* are the values to commit on accept.
module minmax_update #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] cur_min,
  input  logic [WIDTH-1:0] cur_max,
  input  logic [IDX_W-1:0] cur_min_idx,
  input  logic [IDX_W-1:0] cur_max_idx,
  input  logic [IDX_W-1:0] pos,
  output logic [WIDTH-1:0] nxt_min,
  output logic [WIDTH-1:0] nxt_max,
  output logic [IDX_W-1:0] nxt_min_idx,
  output logic [IDX_W-1:0] nxt_max_idx
);

  logic min_agb, min_asb, min_aeb;
  logic max_agb, max_asb, max_aeb;
  logic upd_min, upd_max;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a   (sample),
    .b   (cur_min),
    .agb (min_agb),
    .asb (min_asb),
    .aeb (min_aeb)
  );

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a   (sample),
    .b   (cur_max),
    .agb (max_agb),
    .asb (max_asb),
    .aeb (max_aeb)
  );

  // Strictly below / strictly above only: a tie keeps the earlier index.
  assign upd_min = min_asb & ~(min_aeb | min_agb);
  assign upd_max = max_agb & ~(max_aeb | max_asb);

  always_comb begin
    nxt_min     = cur_min;
    nxt_min_idx = cur_min_idx;
    nxt_max     = cur_max;
    nxt_max_idx = cur_max_idx;
    if (upd_min) begin
      nxt_min     = sample;
      nxt_min_idx = pos;
    end
    if (upd_max) begin
      nxt_max     = sample;
      nxt_max_idx = pos;
    end
  end

endmodule

// File: rtl/frame_minmax_tracker.sv
// Tracks min/max (and first-occurrence index) over a frame of samples.
// Latency: record valid the cycle after the closing sample is accepted.
// Backpressure: in_ready drops while a record waits; out_ready never reaches in_ready combinationally.
//
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data/in_last
// sample stream; out_valid/out_ready handshake with out_min, out_max,
// out_min_idx, out_max_idx, out_count as the registered record.
module frame_minmax_tracker
  import frame_minmax_tracker_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int IDX_W     = idx_width(FRAME_LEN),
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_min_idx,
  output logic [IDX_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d, max_idx_q, max_idx_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] upd_min, upd_max;
  logic [IDX_W-1:0] upd_min_idx, upd_max_idx;
  logic             accept;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;

  // In ACCUM count < FRAME_LEN, so it always fits the index width.
  minmax_update #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_update (
    .sample      (in_data),
    .cur_min     (min_q),
    .cur_max     (max_q),
    .cur_min_idx (min_idx_q),
    .cur_max_idx (max_idx_q),
    .pos         (count_q[IDX_W-1:0]),
    .nxt_min     (upd_min),
    .nxt_max     (upd_max),
    .nxt_min_idx (upd_min_idx),
    .nxt_max_idx (upd_max_idx)
  );

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    max_d     = max_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          min_d     = in_data;
          max_d     = in_data;
          min_idx_d = '0;
          max_idx_d = '0;
          count_d   = CNT_W'(1);
          state_d   = (in_last || FRAME_LEN == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          min_d     = upd_min;
          max_d     = upd_max;
          min_idx_d = upd_min_idx;
          max_idx_d = upd_max_idx;
          count_d   = count_q + CNT_W'(1);
          // Closing on the FRAME_LEN-th sample makes in_last there redundant.
          if (in_last || count_d == CNT_W'(FRAME_LEN)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      max_q     <= max_d;
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
      count_q   <= count_d;
    end
  end

  assign out_min     = min_q;
  assign out_max     = max_q;
  assign out_min_idx = min_idx_q;
  assign out_max_idx = max_idx_q;
  assign out_count   = count_q;

endmodule

// File: tb/tb_frame_minmax_tracker.sv
// Directed bench for frame_minmax_tracker (default WIDTH=16, FRAME_LEN=8).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_frame_minmax_tracker;
  import frame_minmax_tracker_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_min;
  logic [15:0] out_max;
  logic [2:0]  out_min_idx;
  logic [2:0]  out_max_idx;
  logic [3:0]  out_count;

  int total = 0;
  int bad   = 0;

  frame_minmax_tracker dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_min     (out_min),
    .out_max     (out_max),
    .out_min_idx (out_min_idx),
    .out_max_idx (out_max_idx),
    .out_count   (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic rec_t mk(input logic [15:0] mn, input int mni,
                              input logic [15:0] mx, input int mxi, input int c);
    rec_t r;
    r.min_v   = mn;
    r.max_v   = mx;
    r.min_idx = 3'(mni);
    r.max_idx = 3'(mxi);
    r.count   = 4'(c);
    return r;
  endfunction

  task automatic chk_rec(input string tag, input rec_t e);
    chk({tag, ".min"},     32'(out_min),     32'(e.min_v));
    chk({tag, ".min_idx"}, 32'(out_min_idx), 32'(e.min_idx));
    chk({tag, ".max"},     32'(out_max),     32'(e.max_v));
    chk({tag, ".max_idx"}, 32'(out_max_idx), 32'(e.max_idx));
    chk({tag, ".count"},   32'(out_count),   32'(e.count));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until an edge sees in_ready high.
  task automatic send(input logic [15:0] d, input logic last);
    bit done;
    int n;
    done = 1'b0;
    n    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!done) begin
      if (n == 50) begin
        total++;
        bad++;
        $error("FAIL send_timeout observed=no_accept expected=accept data=%0h", d);
        done = 1'b1;
      end else begin
        done = in_ready;
        n++;
        tick();
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  logic [15:0] f1 [8];
  logic [15:0] f6 [8];
  int gap;

  initial begin
    f1[0] = 16'd5;  f1[1] = 16'd3; f1[2] = 16'd9; f1[3] = 16'd3;
    f1[4] = 16'd12; f1[5] = 16'd1; f1[6] = 16'd12; f1[7] = 16'd7;
    f6[0] = 16'd40; f6[1] = 16'd50; f6[2] = 16'd20; f6[3] = 16'd60;
    f6[4] = 16'd20; f6[5] = 16'd70; f6[6] = 16'd10; f6[7] = 16'd70;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk_rec("reset", mk(16'h0000, 0, 16'h0000, 0, 0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Full 8-sample frame, auto close.
    for (int i = 0; i < 8; i++) begin
      send(f1[i], 1'b0);
      if (i == 6) chk("full.valid_before_last", 32'(out_valid), 32'd0);
    end
    chk("full.out_valid", 32'(out_valid), 32'd1);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk_rec("full", mk(16'd1, 5, 16'd12, 4, 8));
    tick();
    chk("full.valid_after_hs", 32'(out_valid), 32'd0);
    chk("full.ready_after_hs", 32'(in_ready), 32'd1);

    // Early close, then backpressure on its record.
    out_ready = 1'b0;
    send(16'h0100, 1'b0);
    send(16'h00FF, 1'b1);
    chk("early.out_valid", 32'(out_valid), 32'd1);
    chk_rec("early", mk(16'h00FF, 1, 16'h0100, 0, 2));
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.out_valid", 32'(out_valid), 32'd1);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk_rec("bp", mk(16'h00FF, 1, 16'h0100, 0, 2));
    end
    out_ready = 1'b1;
    tick();
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp.single_valid", 32'(out_valid), 32'd1);
    chk_rec("bp.single", mk(16'hAAAA, 0, 16'hAAAA, 0, 1));
    tick();

    // Extremes and ties.
    send(16'hFFFF, 1'b0);
    send(16'h0000, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'h0000, 1'b1);
    chk("ext.out_valid", 32'(out_valid), 32'd1);
    chk_rec("ext", mk(16'h0000, 1, 16'hFFFF, 0, 4));
    tick();

    // Bubbles: in_last and junk data driven while in_valid is low; in_last
    // also set on the 8th sample.
    for (int i = 0; i < 8; i++) begin
      gap = int'($urandom_range(0, 3));
      in_valid = 1'b0;
      in_last  = 1'b1;
      in_data  = 16'h0000;
      for (int g = 0; g < gap; g++) tick();
      send(f1[i], (i == 7));
      if (i < 7) chk("bub.no_early_close", 32'(out_valid), 32'd0);
    end
    chk("bub.out_valid", 32'(out_valid), 32'd1);
    chk_rec("bub", mk(16'd1, 5, 16'd12, 4, 8));
    tick();

    // Reset in the middle of a frame.
    send(16'h0001, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'h0002, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk_rec("rst", mk(16'h0000, 0, 16'h0000, 0, 0));
    #1;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) send(f6[i], 1'b0);
    chk("post_rst.out_valid", 32'(out_valid), 32'd1);
    chk_rec("post_rst", mk(16'd10, 6, 16'd70, 5, 8));
    tick();
    chk("post_rst.valid_after_hs", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
